// File: rtl/mesh_term_pkg.sv
// Shared packet-field layout and terminal-address legality for the mesh source terminal.
// Offsets are measured from the packet MSB, so they hold for any packet width.
package mesh_term_pkg;

    localparam int NXTJP_W = 8;
    localparam int ROW_W   = 4;
    localparam int COL_W   = 4;
    localparam int MODE_W  = 1;
    localparam int HDR_W   = NXTJP_W + ROW_W + COL_W + MODE_W;

    // Distance of each field's top bit below the packet MSB
    localparam int NXTJP_OFS = 0;
    localparam int ROW_OFS   = NXTJP_OFS + NXTJP_W;
    localparam int COL_OFS   = ROW_OFS + ROW_W;
    localparam int MODE_OFS  = COL_OFS + COL_W;

    localparam logic [NXTJP_W-1:0] NXTJP_INIT = '0;

    // Terminals sit on the perimeter ring around the ROWS x COLS router array; corners are unused.
    function automatic logic is_legal_term(input logic [ROW_W-1:0] row,
                                           input logic [COL_W-1:0] col,
                                           input int rows,
                                           input int cols);
        int  r;
        int  c;
        logic on_row_edge;
        logic on_col_edge;
        r = int'(row);
        c = int'(col);
        on_row_edge = ((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= cols);
        on_col_edge = ((c == 0) || (c == cols + 1)) && (r >= 1) && (r <= rows);
        return on_row_edge || on_col_edge;
    endfunction

endpackage

// File: rtl/mesh_term_src_if.sv
// Push/pop bundle between the terminal front end and its packet queue.
interface mesh_term_src_if #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4
);
    localparam int CW = $clog2(fifo_depth) + 1;

    logic               push;
    logic [pckg_sz-1:0] push_data;
    logic               pop;
    logic [pckg_sz-1:0] head;
    logic [CW-1:0]      count;

    modport master (output push, push_data, pop, input head, count);
    modport slave  (input push, push_data, pop, output head, count);

endinterface

// File: rtl/mesh_term_fifo.sv
// Show-ahead packet queue: the head entry is readable combinationally whenever count is non-zero.
// A push while full is taken only when a pop frees a slot on the same edge.
module mesh_term_fifo #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4
) (
    input  logic            clk,
    input  logic            srst,
    mesh_term_src_if.slave  q
);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;

    // Asynchronous read keeps the one-edge push-to-visible latency of a show-ahead queue
    logic [pckg_sz-1:0] mem_q [fifo_depth];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;
    logic          push_ok;
    logic          full_w;

    always_comb begin
        full_w   = (count_q == CW'(fifo_depth));
        pop_ok   = q.pop && (count_q != '0);
        push_ok  = q.push && (!full_w || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; only the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push_ok && !srst) begin
            mem_q[wr_ptr_q] <= q.push_data;
        end
    end

    assign q.head  = mem_q[rd_ptr_q];
    assign q.count = count_q;

endmodule

// File: rtl/mesh_term_src.sv
// Mesh source terminal: validates the destination, assembles the packet and queues it for the router.
// Illegal destinations and writes lost to a full queue are tallied in saturating counters.
module mesh_term_src
    import mesh_term_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [3:0]                      dst_row,
    input  logic [3:0]                      dst_colum,
    input  logic                            mode,
    input  logic [pckg_sz-18:0]             payload,
    input  logic                            popin,
    output logic [pckg_sz-1:0]              data_out_i_in,
    output logic                            pndng_i_in,
    output logic                            full,
    output logic [$clog2(fifo_depth):0]     count,
    output logic [7:0]                      drop_cnt,
    output logic [7:0]                      err_cnt
);
    localparam int CW = $clog2(fifo_depth) + 1;

    mesh_term_src_if #(.pckg_sz(pckg_sz), .fifo_depth(fifo_depth)) q_if ();

    mesh_term_fifo #(.pckg_sz(pckg_sz), .fifo_depth(fifo_depth)) u_fifo (
        .clk  (clk),
        .srst (reset),
        .q    (q_if.slave)
    );

    logic [pckg_sz-1:0] pkt;
    logic               legal;
    logic               full_w;
    logic [7:0]         err_q, err_d;
    logic [7:0]         drop_q, drop_d;

    always_comb begin
        pkt = '0;
        pkt[pckg_sz-1-NXTJP_OFS -: NXTJP_W] = NXTJP_INIT;
        pkt[pckg_sz-1-ROW_OFS   -: ROW_W]   = dst_row;
        pkt[pckg_sz-1-COL_OFS   -: COL_W]   = dst_colum;
        pkt[pckg_sz-1-MODE_OFS]             = mode;
        pkt[pckg_sz-1-HDR_W:0]              = payload;
    end

    always_comb begin
        legal  = is_legal_term(dst_row, dst_colum, ROWS, COLUMS);
        full_w = (q_if.count == CW'(fifo_depth));
        err_d  = err_q;
        drop_d = drop_q;
        // Destination check wins: an illegal write never reaches the full/drop accounting
        if (wr_en && !legal && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        if (wr_en && legal && full_w && !popin && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q  <= '0;
            drop_q <= '0;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign q_if.push      = wr_en && legal;
    assign q_if.push_data = pkt;
    assign q_if.pop       = popin;

    assign data_out_i_in = q_if.head;
    assign count         = q_if.count;
    assign pndng_i_in    = (q_if.count != '0);
    assign full          = full_w;
    assign drop_cnt      = drop_q;
    assign err_cnt       = err_q;

endmodule

// File: doc/mesh_term_src.md
MESH_TERM_SRC -- requirements
Module: mesh_term_src

Interface
REQ-001 SHALL have parameter ROWS, default 4: mesh row count.
REQ-002 SHALL have parameter COLUMS, default 4: mesh column count.
REQ-003 SHALL have parameter pckg_sz, default 40: packet width in bits.
REQ-004 SHALL have parameter fifo_depth, default 4: queue entries; a power of two, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit: request to enqueue one packet this cycle.
REQ-008 SHALL have port dst_row, input, 4 bits: destination terminal row.
REQ-009 SHALL have port dst_colum, input, 4 bits: destination terminal column.
REQ-010 SHALL have port mode, input, 1 bit: routing-mode bit.
REQ-011 SHALL have port payload, input, pckg_sz-17 bits: user data.
REQ-012 SHALL have port popin, input, 1 bit: the router's pop of the head packet.
REQ-013 SHALL have port data_out_i_in, output, pckg_sz bits: head packet presented to the router.
REQ-014 SHALL have port pndng_i_in, output, 1 bit: queue non-empty.
REQ-015 SHALL have port full, output, 1 bit: queue holds fifo_depth entries.
REQ-016 SHALL have port count, output, $clog2(fifo_depth)+1 bits: current occupancy.
REQ-017 SHALL have port drop_cnt, output, 8 bits: writes lost because the queue was full.
REQ-018 SHALL have port err_cnt, output, 8 bits: writes rejected for an illegal destination.

Function
REQ-019 SHALL assemble each packet as {Nxtjp=8'h00, dst_row, dst_colum, mode, payload}, MSB first; field bounds [pckg_sz-1:pckg_sz-8], [pckg_sz-9:pckg_sz-12], [pckg_sz-13:pckg_sz-16], [pckg_sz-17], [pckg_sz-18:0].
REQ-020 SHALL treat a destination as legal only when it is a perimeter terminal: (row 0 or ROWS+1, with colum 1..COLUMS) or (colum 0 or COLUMS+1, with row 1..ROWS).
REQ-021 SHALL enqueue on a clock edge when wr_en=1, the destination is legal, and the queue is not full (see REQ-025 for the full case).
REQ-022 SHALL, when wr_en=1 with an illegal destination, discard the write and increment err_cnt; the illegal check takes precedence over the full check.
REQ-023 SHALL, when wr_en=1 with a legal destination while full and popin=0, discard the write and increment drop_cnt.
REQ-024 SHALL dequeue on a clock edge when popin=1 and pndng_i_in=1; popin while empty SHALL be ignored.
REQ-025 SHALL, on a simultaneous push and pop while full, accept the push; count is unchanged.
REQ-026 SHALL, on a simultaneous push and pop while empty, accept the push and ignore the pop; count becomes 1.
REQ-027 SHALL present data_out_i_in in show-ahead form: the head entry is valid whenever pndng_i_in=1, and the value is don't-care otherwise.
REQ-028 SHALL have one cycle of latency: a push at edge N makes pndng_i_in=1 and data_out_i_in valid after edge N.
REQ-029 SHALL wrap read and write pointers modulo fifo_depth.
REQ-030 SHALL deliver packets in FIFO order.
REQ-031 SHALL make drop_cnt and err_cnt saturate at 255.
REQ-032 SHALL drive pndng_i_in=(count!=0) and full=(count==fifo_depth), both combinationally from count.

Reset
REQ-033 SHALL, with reset=1 at a clock edge, clear count, the pointers, drop_cnt and err_cnt; this yields pndng_i_in=0 and full=0.
REQ-034 SHALL give reset precedence over a concurrent wr_en or popin; an in-flight push is lost and not counted.
REQ-035 SHALL not reset the storage array; data_out_i_in is don't-care while empty.

Structure
REQ-036 SHALL place the Nxtjp/row/colum/mode field widths, field offsets and a legal-terminal function in package mesh_term_pkg.
REQ-037 SHALL implement the queue as sub-module mesh_term_fifo, parameterised by pckg_sz and fifo_depth; destination check, packet assembly and counters stay in the top level.

Verification
REQ-038 SHALL cover: reset, then push row=0 colum=2 mode=1 payload=5'b10101 -> one cycle later pndng_i_in=1 and data_out_i_in={8'h00,4'h0,4'h2,1'b1,payload}; popin=1 -> pndng_i_in=0.
REQ-039 SHALL cover: 5 legal pushes with fifo_depth=4 and no pops -> full=1, count=4, drop_cnt=1; pops return the first 4 packets in order.
REQ-040 SHALL cover: push to row=2 colum=2 (interior) and to row=0 colum=0 (corner) -> err_cnt=2, count=0.
REQ-041 SHALL cover: while full, push and popin in the same cycle -> count stays 4, drop_cnt unchanged, and the new packet is read last.
REQ-042 SHALL cover: while empty, popin and push in the same cycle -> count=1; then assert reset with wr_en=1 -> count=0 and drop_cnt=err_cnt=0.
REQ-043 SHALL cover: 300 illegal writes -> err_cnt=255, saturated.
